// File: rtl/dpm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_arb_pkg
//  Purpose  : Shared constants, helper function and types for the dual-port
//             memory port arbiter.
//             - req_idx_w()  : index width for a given requester count
//             - rsp_tag_t    : per-port response tag {vld, id}
//             - STATS_W      : width of the optional conflict counter
//  Revision : 1.0  initial release
// ============================================================================
package dpm_arb_pkg;

    localparam int STATS_W   = 16;
    // Widest requester index supported (NUM_REQ <= 8).
    localparam int MAX_IDX_W = 3;

    // Index width for n requesters; never narrower than one bit.
    function automatic int req_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Remembers which requester a read issued on a port belongs to, so the
    // registered memory data can be steered back one cycle later.
    typedef struct packed {
        logic                 vld;
        logic [MAX_IDX_W-1:0] id;
    } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/dpm_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_rr_pick
//  Purpose  : Rotating-priority picker. Scans mask starting at index start,
//             wrapping past N-1 back to 0, and returns the first set bit.
//  Ports    : mask  [N-1:0]      candidate requesters
//             start [IDX_W-1:0]  first index to consider (must be < N)
//             found              at least one candidate present
//             idx   [IDX_W-1:0]  winning index (0 when nothing found)
//  Revision : 1.0  initial release
// ============================================================================
module dpm_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int w_cand;

    // Walk the scan order backwards so the candidate closest to start is the
    // last one written and therefore wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = int'(start) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (mask[w_cand]) begin
                found = 1'b1;
                idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dpm_port_arbiter
//  Purpose  : Shares one dual-port memory (registered read, 1-cycle latency)
//             between NUM_REQ requesters. Grants up to two requests per cycle
//             with round-robin fairness, never issuing a same-address pair
//             that involves a write, and routes read data back to the
//             originating requester one cycle after the grant.
//  Ports    : clk, rst_n (synchronous, active-low)
//             req/req_we/req_addr/req_wdata  requester side (packed per slot)
//             gnt                            combinational grant
//             rsp_valid/rsp_rdata            read return (packed per slot)
//             mem_we*/mem_addr*/mem_wdata*   memory drive, ports 0 and 1
//             mem_rdata0/1                   registered memory read data
//             conflict_cnt                   only with DPM_ARB_STATS_EN
//  Options  : `define DPM_ARB_STATS_EN adds a 16-bit saturating counter of
//             cycles in which a requester was skipped for port 1 because of
//             an address conflict.
//  Revision : 1.0  initial release
// ============================================================================
module dpm_port_arbiter
    import dpm_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_DEPTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_DEPTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
    output logic                          mem_we0,
    output logic                          mem_we1,
    output logic [DATA_DEPTH-1:0]         mem_addr0,
    output logic [DATA_DEPTH-1:0]         mem_addr1,
    output logic [DATA_WIDTH-1:0]         mem_wdata0,
    output logic [DATA_WIDTH-1:0]         mem_wdata1,
    input  logic [DATA_WIDTH-1:0]         mem_rdata0,
    input  logic [DATA_WIDTH-1:0]         mem_rdata1
`ifdef DPM_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]            conflict_cnt
`endif
);

    localparam int c_idx_w = req_idx_w(NUM_REQ);

    logic [c_idx_w-1:0]    r_rr_ptr;
    rsp_tag_t              r_p0_tag;
    rsp_tag_t              r_p1_tag;

    logic                  w_found0;
    logic                  w_found1;
    logic [c_idx_w-1:0]    w_win0;
    logic [c_idx_w-1:0]    w_win1;
    logic [c_idx_w-1:0]    w_start1;
    logic [NUM_REQ-1:0]    w_win0_oh;
    logic [NUM_REQ-1:0]    w_compat;
    logic [NUM_REQ-1:0]    w_mask1;
    logic                  w_conflict;
    logic                  w_g0;
    logic                  w_g1;
    logic                  w_we0;
    logic                  w_we1;
    logic [DATA_DEPTH-1:0] w_addr0;
    logic [DATA_DEPTH-1:0] w_addr1;
    logic [DATA_WIDTH-1:0] w_wdata0;
    logic [DATA_WIDTH-1:0] w_wdata1;

    // Index following idx, wrapping at NUM_REQ (which need not be a power
    // of two).
    function automatic logic [c_idx_w-1:0] f_next(input logic [c_idx_w-1:0] idx);
        return (idx == c_idx_w'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    dpm_rr_pick #(.N(NUM_REQ), .IDX_W(c_idx_w)) u_pick0 (
        .mask  (req),
        .start (r_rr_ptr),
        .found (w_found0),
        .idx   (w_win0)
    );

    // Port-0 winner's attributes, then compatibility of every other request
    // against it: a different address, or both sides reading.
    always_comb begin
        w_we0     = 1'b0;
        w_addr0   = '0;
        w_wdata0  = '0;
        w_win0_oh = '0;
        w_compat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found0 && (w_win0 == c_idx_w'(i))) begin
                w_we0        = req_we[i];
                w_addr0      = req_addr[i*DATA_DEPTH +: DATA_DEPTH];
                w_wdata0     = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_win0_oh[i] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            w_compat[j] = (req_addr[j*DATA_DEPTH +: DATA_DEPTH] != w_addr0) ||
                          (!req_we[j] && !w_we0);
        end
    end

    assign w_start1   = f_next(w_win0);
    assign w_mask1    = req & ~w_win0_oh & w_compat & {NUM_REQ{w_found0}};
    assign w_conflict = w_found0 && (|(req & ~w_win0_oh & ~w_compat));

    dpm_rr_pick #(.N(NUM_REQ), .IDX_W(c_idx_w)) u_pick1 (
        .mask  (w_mask1),
        .start (w_start1),
        .found (w_found1),
        .idx   (w_win1)
    );

    always_comb begin
        w_we1    = 1'b0;
        w_addr1  = '0;
        w_wdata1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found1 && (w_win1 == c_idx_w'(i))) begin
                w_we1    = req_we[i];
                w_addr1  = req_addr[i*DATA_DEPTH +: DATA_DEPTH];
                w_wdata1 = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Nothing is granted while reset is held, so memory is never written
    // and no requester believes its request was taken.
    assign w_g0 = w_found0 & rst_n;
    assign w_g1 = w_found1 & rst_n;

    always_comb begin
        gnt = '0;
        if (w_g0) begin
            gnt[w_win0] = 1'b1;
        end
        if (w_g1) begin
            gnt[w_win1] = 1'b1;
        end
    end

    assign mem_we0    = w_g0 & w_we0;
    assign mem_addr0  = w_g0 ? w_addr0  : '0;
    assign mem_wdata0 = w_g0 ? w_wdata0 : '0;
    assign mem_we1    = w_g1 & w_we1;
    assign mem_addr1  = w_g1 ? w_addr1  : '0;
    assign mem_wdata1 = w_g1 ? w_wdata1 : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_p0_tag <= '0;
            r_p1_tag <= '0;
        end else begin
            if (w_g1) begin
                r_rr_ptr <= f_next(w_win1);
            end else if (w_g0) begin
                r_rr_ptr <= f_next(w_win0);
            end
            r_p0_tag.vld <= w_g0 & ~w_we0;
            r_p0_tag.id  <= MAX_IDX_W'(w_win0);
            r_p1_tag.vld <= w_g1 & ~w_we1;
            r_p1_tag.id  <= MAX_IDX_W'(w_win1);
        end
    end

    // The two tags always name different requesters, so at most one port
    // lands in any slot.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && r_p0_tag.vld && (r_p0_tag.id == MAX_IDX_W'(i))) begin
                rsp_valid[i]                         = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata0;
            end
            if (rst_n && r_p1_tag.vld && (r_p1_tag.id == MAX_IDX_W'(i))) begin
                rsp_valid[i]                         = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata1;
            end
        end
    end

`ifdef DPM_ARB_STATS_EN
    logic [STATS_W-1:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {STATS_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    // Conflict detection only feeds the statistics counter.
    logic w_unused_conflict;
    assign w_unused_conflict = w_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dpm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpm_port_arbiter
//  Purpose  : Directed self-checking bench for dpm_port_arbiter with a small
//             behavioural dual-port memory (registered read) attached.
//             Inputs change 1 time unit after posedge; outputs are sampled
//             on the following negedge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dpm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_we0;
    logic        mem_we1;
    logic [2:0]  mem_addr0;
    logic [2:0]  mem_addr1;
    logic [7:0]  mem_wdata0;
    logic [7:0]  mem_wdata1;
    logic [7:0]  mem_rdata0;
    logic [7:0]  mem_rdata1;
`ifdef DPM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    // Backdoor preload port into the memory model.
    logic        pl_we = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [7:0]  pl_data = '0;
    logic [7:0]  mem_model [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpm_port_arbiter #(.NUM_REQ(4), .DATA_DEPTH(3), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_we0    (mem_we0),
        .mem_we1    (mem_we1),
        .mem_addr0  (mem_addr0),
        .mem_addr1  (mem_addr1),
        .mem_wdata0 (mem_wdata0),
        .mem_wdata1 (mem_wdata1),
        .mem_rdata0 (mem_rdata0),
        .mem_rdata1 (mem_rdata1)
`ifdef DPM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Dual-port memory, registered read (old data on read-during-write).
    always @(posedge clk) begin
        if (pl_we)   mem_model[pl_addr]   <= pl_data;
        if (mem_we0) mem_model[mem_addr0] <= mem_wdata0;
        if (mem_we1) mem_model[mem_addr1] <= mem_wdata1;
        mem_rdata0 <= mem_model[mem_addr0];
        mem_rdata1 <= mem_model[mem_addr1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [2:0] a,
                           input logic [7:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*3 +: 3]  = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_reqs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 8'hFF);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt);
        end
        total++;
        if ({mem_we0, mem_we1} !== 2'b00) begin
            bad++; $display("FAIL reset_mem_we got=%b exp=00", {mem_we0, mem_we1});
        end
        tick();
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid);
        end
`ifdef DPM_ARB_STATS_EN
        total++;
        if (conflict_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_conflict_cnt got=%0d exp=0", conflict_cnt);
        end
`endif
        tick();
        clear_reqs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        preload(3'd3, 8'hA5);
        set_req(0, 1'b0, 3'd3, 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++; $display("FAIL single_gnt got=%b exp=0001", gnt);
        end
        total++;
        if ({mem_we0, mem_addr0, mem_we1, mem_addr1} !== {1'b0, 3'd3, 1'b0, 3'd0}) begin
            bad++; $display("FAIL single_mem got we0=%b a0=%0d we1=%b a1=%0d exp 0/3/0/0",
                            mem_we0, mem_addr0, mem_we1, mem_addr1);
        end
        tick();
        clear_reqs();
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h0000_00A5) begin
            bad++; $display("FAIL single_rsp got v=%b d=%h exp v=0001 d=000000a5",
                            rsp_valid, rsp_rdata);
        end
        tick();
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL single_rsp_once got=%b exp=0000", rsp_valid);
        end
    endtask

    task automatic test_all_reads();
        do_reset();
        for (int i = 0; i < 4; i++) preload(3'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3'(i), 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0011 || mem_addr0 !== 3'd0 || mem_addr1 !== 3'd1) begin
            bad++; $display("FAIL all_c0 got gnt=%b a0=%0d a1=%0d exp 0011/0/1",
                            gnt, mem_addr0, mem_addr1);
        end
        tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b1100 || mem_addr0 !== 3'd2 || mem_addr1 !== 3'd3) begin
            bad++; $display("FAIL all_c1 got gnt=%b a0=%0d a1=%0d exp 1100/2/3",
                            gnt, mem_addr0, mem_addr1);
        end
        total++;
        if (rsp_valid !== 4'b0011 || rsp_rdata !== 32'h0000_1110) begin
            bad++; $display("FAIL all_rsp01 got v=%b d=%h exp v=0011 d=00001110",
                            rsp_valid, rsp_rdata);
        end
        tick();
        clear_reqs();
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b1100 || rsp_rdata !== 32'h1312_0000) begin
            bad++; $display("FAIL all_rsp23 got v=%b d=%h exp v=1100 d=13120000",
                            rsp_valid, rsp_rdata);
        end
        // Pointer should have wrapped back to requester 0.
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3'(i), 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0011) begin
            bad++; $display("FAIL all_wrap got=%b exp=0011", gnt);
        end
        tick();
        clear_reqs();
        tick();
    endtask

    task automatic test_write_conflict();
        do_reset();
        set_req(0, 1'b1, 3'd5, 8'h11);
        set_req(1, 1'b0, 3'd5, 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++; $display("FAIL wc_gnt0 got=%b exp=0001", gnt);
        end
        total++;
        if ({mem_we0, mem_addr0, mem_wdata0} !== {1'b1, 3'd5, 8'h11} ||
            {mem_we1, mem_addr1, mem_wdata1} !== 12'h000) begin
            bad++; $display("FAIL wc_mem got p0=%b/%0d/%h p1=%b/%0d/%h exp 1/5/11 0/0/00",
                            mem_we0, mem_addr0, mem_wdata0, mem_we1, mem_addr1, mem_wdata1);
        end
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010 || mem_we0 !== 1'b0 || mem_addr0 !== 3'd5) begin
            bad++; $display("FAIL wc_gnt1 got gnt=%b we0=%b a0=%0d exp 0010/0/5",
                            gnt, mem_we0, mem_addr0);
        end
        total++;
        if (rsp_valid !== 4'b0000) begin
            bad++; $display("FAIL wc_no_rsp_write got=%b exp=0000", rsp_valid);
        end
        tick();
        clear_reqs();
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0010 || rsp_rdata[15:8] !== 8'h11) begin
            bad++; $display("FAIL wc_rsp got v=%b d1=%h exp v=0010 d1=11",
                            rsp_valid, rsp_rdata[15:8]);
        end
    endtask

    task automatic test_same_addr_reads();
        do_reset();
        preload(3'd7, 8'h5C);
        set_req(1, 1'b0, 3'd7, 8'h00);
        set_req(2, 1'b0, 3'd7, 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0110 || mem_addr0 !== 3'd7 || mem_addr1 !== 3'd7) begin
            bad++; $display("FAIL same_gnt got gnt=%b a0=%0d a1=%0d exp 0110/7/7",
                            gnt, mem_addr0, mem_addr1);
        end
        tick();
        clear_reqs();
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0110 || rsp_rdata !== 32'h005C_5C00) begin
            bad++; $display("FAIL same_rsp got v=%b d=%h exp v=0110 d=005c5c00",
                            rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        preload(3'd3, 8'hA5);
        set_req(0, 1'b0, 3'd3, 8'h00);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++; $display("FAIL mid_gnt got=%b exp=0001", gnt);
        end
        tick();
        clear_reqs();
        set_req(2, 1'b0, 3'd0, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0000 || gnt !== 4'b0000) begin
            bad++; $display("FAIL mid_in_reset got v=%b gnt=%b exp 0000/0000",
                            rsp_valid, gnt);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 3'(i), 8'h00);
        @(negedge clk);
        total++;
        if (rsp_valid !== 4'b0000 || gnt !== 4'b0011) begin
            bad++; $display("FAIL mid_after got v=%b gnt=%b exp 0000/0011",
                            rsp_valid, gnt);
        end
        tick();
        clear_reqs();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 1'b1, 3'd2, 8'hA0);
        set_req(1, 1'b1, 3'd2, 8'hB0);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || mem_wdata0 !== 8'hA0 || mem_we1 !== 1'b0) begin
            bad++; $display("FAIL b2b_c0 got gnt=%b wd0=%h we1=%b exp 0001/a0/0",
                            gnt, mem_wdata0, mem_we1);
        end
        tick();
        total++;
        if (mem_model[2] !== 8'hA0) begin
            bad++; $display("FAIL b2b_mem0 got=%h exp=a0", mem_model[2]);
        end
        set_req(0, 1'b1, 3'd2, 8'hA1);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010 || mem_wdata0 !== 8'hB0 || mem_we1 !== 1'b0) begin
            bad++; $display("FAIL b2b_c1 got gnt=%b wd0=%h we1=%b exp 0010/b0/0",
                            gnt, mem_wdata0, mem_we1);
        end
        tick();
        total++;
        if (mem_model[2] !== 8'hB0) begin
            bad++; $display("FAIL b2b_mem1 got=%h exp=b0", mem_model[2]);
        end
        set_req(1, 1'b1, 3'd2, 8'hB1);
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || mem_wdata0 !== 8'hA1 || mem_we1 !== 1'b0) begin
            bad++; $display("FAIL b2b_c2 got gnt=%b wd0=%h we1=%b exp 0001/a1/0",
                            gnt, mem_wdata0, mem_we1);
        end
        tick();
        total++;
        if (mem_model[2] !== 8'hA1) begin
            bad++; $display("FAIL b2b_mem2 got=%h exp=a1", mem_model[2]);
        end
        clear_reqs();
        tick();
        @(negedge clk);
`ifdef DPM_ARB_STATS_EN
        total++;
        if (conflict_cnt !== 16'd3) begin
            bad++; $display("FAIL b2b_conflict_cnt got=%0d exp=3", conflict_cnt);
        end
`endif
        total++;
        if (mem_model[2] !== 8'hA1 || gnt !== 4'b0000) begin
            bad++; $display("FAIL b2b_idle got mem=%h gnt=%b exp a1/0000",
                            mem_model[2], gnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        test_reset();
        test_single_read();
        test_all_reads();
        test_write_conflict();
        test_same_addr_reads();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
